milano_lsu_ctrl: RTL

Load/store controller for the milano RV32I core. It sits between the execute stage and the data-memory port. It accepts one LOAD/STORE operation at a time, with the effective address already computed by the ALU (ALU_ADD). It sequences the req/gnt/rvalid bus handshake and generates byte enables. It aligns and sign/zero-extends load data, and optionally splits misaligned accesses into two bus transactions.

---
 rtl/milano_lsu_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/milano_lsu_ctrl.sv
// milano_lsu_ctrl: RV32I load/store controller between the execute stage and the data-memory port.
// Latency: 3 cycles for an aligned access with zero bus wait (+1 per gnt or rvalid wait cycle); 5 for a split access; 1 for a rejected misaligned access.
// Backpressure: one operation at a time; lsu_req_i is ignored while lsu_busy_o=1, and each bus request is held stable until data_gnt_i.
//
// Build option: define MILANO_LSU_MISALIGNED_EN to split misaligned accesses into two
// word-aligned bus transactions. Without it, REQ2/WAIT2 are not built and misaligned
// accesses complete in one cycle with lsu_err_o=1 and no bus activity.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   lsu_req_i/we/type/sign_ext/addr/wdata   operation from execute (type 00=B, 01=H, 1x=W)
//   lsu_busy_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o   status and completion back to the core
//   data_req_o/gnt_i/we_o/be_o/addr_o/wdata_o       bus request channel
//   data_rvalid_i/rdata_i/err_i                      bus response channel
module milano_lsu_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_type_i,
    input  logic                  lsu_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [31:0]           lsu_wdata_i,
    output logic                  lsu_busy_o,
    output logic                  lsu_rvalid_o,
    output logic [31:0]           lsu_rdata_o,
    output logic                  lsu_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    input  logic                  data_err_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ1,
        S_WAIT1,
        S_REQ2,
        S_WAIT2,
        S_DONE
    } state_e;

    state_e      state_q;
    logic        we_q;
    logic [1:0]  type_q;
    logic        sext_q;
    logic [1:0]  off_q;
`ifdef MILANO_LSU_MISALIGNED_EN
    logic        split_q;
    logic [3:0]  be2_q;
    logic [31:0] rdata1_q;
`endif

    // ---------------------------------------------------------------
    // Request decode (from the incoming operation)
    // ---------------------------------------------------------------
    logic [1:0]  req_off;
    logic [4:0]  req_sh;
    logic [3:0]  req_mask;
    logic        req_misal;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
`ifdef MILANO_LSU_MISALIGNED_EN
    logic [3:0]  req_be2;
`endif

    always_comb begin
        req_off = lsu_addr_i[1:0];
        req_sh  = {req_off, 3'b000};
        case (lsu_type_i)
            2'b00:   req_mask = 4'b0001;
            2'b01:   req_mask = 4'b0011;
            default: req_mask = 4'b1111;
        endcase
        req_misal = (lsu_type_i[1] && (req_off != 2'b00)) ||
                    ((lsu_type_i == 2'b01) && (req_off == 2'b11));
        // For a split access this is the first beat's lanes; upper bits fall off.
        req_be = req_mask << req_off;
        case (lsu_type_i)
            2'b00:   req_wdata = {4{lsu_wdata_i[7:0]}};
            2'b01:   req_wdata = {2{lsu_wdata_i[15:0]}};
            default: req_wdata = lsu_wdata_i;
        endcase
`ifdef MILANO_LSU_MISALIGNED_EN
        // Lanes that spilled past byte 3 in the first beat land in the low lanes of the second.
        req_be2 = req_mask >> (3'd4 - {1'b0, req_off});
        // Rotating puts every byte in its correct lane for both beats at once.
        if (req_misal) begin
            req_wdata = (lsu_wdata_i << req_sh) | (lsu_wdata_i >> (6'd32 - {1'b0, req_sh}));
        end
`endif
    end

    // ---------------------------------------------------------------
    // Response alignment and extension
    // ---------------------------------------------------------------
    logic [4:0]  rsp_sh;
    logic [31:0] rsp_raw;
    logic [31:0] rsp_ext;

    always_comb begin
        rsp_sh  = {off_q, 3'b000};
        rsp_raw = data_rdata_i >> rsp_sh;
`ifdef MILANO_LSU_MISALIGNED_EN
        if (state_q == S_WAIT2) begin
            rsp_raw = (rdata1_q >> rsp_sh) | (data_rdata_i << (6'd32 - {1'b0, rsp_sh}));
        end
`endif
        case (type_q)
            2'b00:   rsp_ext = {{24{sext_q & rsp_raw[7]}}, rsp_raw[7:0]};
            2'b01:   rsp_ext = {{16{sext_q & rsp_raw[15]}}, rsp_raw[15:0]};
            default: rsp_ext = rsp_raw;
        endcase
    end

    // ---------------------------------------------------------------
    // Control FSM; every output is registered here
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            type_q       <= 2'b00;
            sext_q       <= 1'b0;
            off_q        <= 2'b00;
`ifdef MILANO_LSU_MISALIGNED_EN
            split_q      <= 1'b0;
            be2_q        <= 4'b0000;
            rdata1_q     <= '0;
`endif
            lsu_busy_o   <= 1'b0;
            lsu_rvalid_o <= 1'b0;
            lsu_rdata_o  <= '0;
            lsu_err_o    <= 1'b0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
        end else begin
            // Completion outputs are single-cycle pulses.
            lsu_rvalid_o <= 1'b0;
            lsu_err_o    <= 1'b0;
            lsu_rdata_o  <= '0;

            case (state_q)
                // DONE accepts a new operation exactly like IDLE (back-to-back).
                S_IDLE, S_DONE: begin
                    state_q    <= S_IDLE;
                    lsu_busy_o <= 1'b0;
                    if (lsu_req_i) begin
                        we_q         <= lsu_we_i;
                        type_q       <= lsu_type_i;
                        sext_q       <= lsu_sign_ext_i;
                        off_q        <= req_off;
                        data_addr_o  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        data_we_o    <= lsu_we_i;
                        data_be_o    <= req_be;
                        data_wdata_o <= req_wdata;
`ifdef MILANO_LSU_MISALIGNED_EN
                        split_q      <= req_misal;
                        be2_q        <= req_be2;
                        state_q      <= S_REQ1;
                        data_req_o   <= 1'b1;
                        lsu_busy_o   <= 1'b1;
`else
                        // Misaligned: finish immediately with an error, never touch the bus.
                        state_q      <= req_misal ? S_DONE : S_REQ1;
                        data_req_o   <= ~req_misal;
                        lsu_busy_o   <= ~req_misal;
                        lsu_rvalid_o <= req_misal;
                        lsu_err_o    <= req_misal;
`endif
                    end
                end

                S_REQ1: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state_q    <= S_WAIT1;
                    end
                end

                S_WAIT1: begin
                    if (data_rvalid_i) begin
`ifdef MILANO_LSU_MISALIGNED_EN
                        if (split_q && !data_err_i) begin
                            rdata1_q    <= data_rdata_i;
                            data_addr_o <= data_addr_o + ADDR_WIDTH'(4);
                            data_be_o   <= be2_q;
                            data_req_o  <= 1'b1;
                            state_q     <= S_REQ2;
                        end else
`endif
                        begin
                            state_q      <= S_DONE;
                            lsu_busy_o   <= 1'b0;
                            lsu_rvalid_o <= 1'b1;
                            lsu_err_o    <= data_err_i;
                            lsu_rdata_o  <= (data_err_i || we_q) ? '0 : rsp_ext;
                        end
                    end
                end

`ifdef MILANO_LSU_MISALIGNED_EN
                S_REQ2: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state_q    <= S_WAIT2;
                    end
                end

                S_WAIT2: begin
                    if (data_rvalid_i) begin
                        state_q      <= S_DONE;
                        lsu_busy_o   <= 1'b0;
                        lsu_rvalid_o <= 1'b1;
                        lsu_err_o    <= data_err_i;
                        lsu_rdata_o  <= (data_err_i || we_q) ? '0 : rsp_ext;
                    end
                end
`endif

                default: begin
                    state_q    <= S_IDLE;
                    data_req_o <= 1'b0;
                    lsu_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
